// File: rtl/spi_pkg.sv
// Shared types for the SPI calculator return path.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  localparam int FRAME_W = 8;

  typedef struct packed {
    logic       n;
    logic       z;
    logic       c;
    logic       v;
    logic [3:0] r;
  } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous input, followed by single-cycle
// rise/fall pulses taken against one extra history flop.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus edge-history flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/spi_result_tx.sv
// SPI mode-0 return path: captures {flags,result} into a frame and shifts it
// out MSB-first on spi_MISO during the next chip-select window.
module spi_result_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W+3:0] IDLE_BYTE   = {(DATA_W+4){1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result,
  input  logic [3:0]        flags,
  input  logic              result_valid,
  input  logic              spi_sck,
  input  logic              cs,
  output logic              spi_MISO,
  output logic              miso_oe,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              overrun,
  output logic [7:0]        tx_count
);

  localparam int FRAME_LEN = DATA_W + 4;
  localparam int MSB       = FRAME_LEN - 1;
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);

  logic                 sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
  logic [FRAME_LEN-1:0] new_frame_s, idle_load_s, pend_data_s;
  logic                 pend_valid_s, pend_ovr_s;

  tx_state_t            state_r;
  logic [FRAME_LEN-1:0] frame_r, pending_r, shift_r;
  logic                 pending_v_r, armed_tx_r;
  logic [BIT_W-1:0]     bit_cnt_r;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk (clk), .rst (rst), .din (spi_sck), .rise (sck_rise_s), .fall (sck_fall_s)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk (clk), .rst (rst), .din (cs), .rise (cs_rise_s), .fall (cs_fall_s)
  );

  // Incoming frame, IDLE-state load value and the would-be pending slot
  always_comb begin
    new_frame_s  = {flags, result};
    idle_load_s  = IDLE_BYTE;
    pend_data_s  = pending_r;
    pend_valid_s = pending_v_r;
    pend_ovr_s   = 1'b0;
    if (result_valid) begin
      idle_load_s  = new_frame_s;
      pend_data_s  = new_frame_s;
      pend_valid_s = 1'b1;
      pend_ovr_s   = pending_v_r;
    end else begin
      idle_load_s  = IDLE_BYTE;
      pend_data_s  = pending_r;
      pend_valid_s = pending_v_r;
      pend_ovr_s   = 1'b0;
    end
  end

  // Transmit FSM with frame/pending/shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      frame_r     <= '0;
      pending_r   <= '0;
      pending_v_r <= 1'b0;
      shift_r     <= '0;
      armed_tx_r  <= 1'b0;
      bit_cnt_r   <= '0;
      spi_MISO    <= 1'b0;
      miso_oe     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      overrun     <= 1'b0;
      tx_count    <= 8'd0;
    end else begin
      tx_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            shift_r    <= idle_load_s;
            spi_MISO   <= idle_load_s[MSB];
            armed_tx_r <= result_valid;
            bit_cnt_r  <= '0;
            miso_oe    <= 1'b1;
            tx_busy    <= 1'b1;
            state_r    <= SHIFT;
          end else if (result_valid) begin
            frame_r <= new_frame_s;
            state_r <= ARMED;
          end
        end
        ARMED: begin
          if (cs_fall_s) begin
            shift_r     <= frame_r;
            spi_MISO    <= frame_r[MSB];
            armed_tx_r  <= 1'b1;
            bit_cnt_r   <= '0;
            pending_r   <= new_frame_s;
            pending_v_r <= result_valid;
            miso_oe     <= 1'b1;
            tx_busy     <= 1'b1;
            state_r     <= SHIFT;
          end else if (result_valid) begin
            frame_r <= new_frame_s;
            overrun <= 1'b1;
          end
        end
        SHIFT: begin
          pending_r   <= pend_data_s;
          pending_v_r <= pend_valid_s;
          if (pend_ovr_s) overrun <= 1'b1;
          if (cs_rise_s) begin
            // Short frame: an armed frame stays armed unless pending displaces it
            spi_MISO <= 1'b0;
            miso_oe  <= 1'b0;
            tx_busy  <= 1'b0;
            if (pend_valid_s) begin
              frame_r     <= pend_data_s;
              pending_v_r <= 1'b0;
              state_r     <= ARMED;
              if (armed_tx_r) overrun <= 1'b1;
            end else if (armed_tx_r) begin
              state_r <= ARMED;
            end else begin
              state_r <= IDLE;
            end
          end else if (sck_rise_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= DONE;
              if (armed_tx_r) begin
                tx_done  <= 1'b1;
                tx_count <= tx_count + 8'd1;
              end
            end
          end else if (sck_fall_s) begin
            shift_r  <= {shift_r[MSB-1:0], 1'b0};
            spi_MISO <= shift_r[MSB-1];
          end
        end
        DONE: begin
          pending_r   <= pend_data_s;
          pending_v_r <= pend_valid_s;
          if (pend_ovr_s) overrun <= 1'b1;
          if (cs_rise_s) begin
            spi_MISO <= 1'b0;
            miso_oe  <= 1'b0;
            tx_busy  <= 1'b0;
            if (pend_valid_s) begin
              frame_r     <= pend_data_s;
              pending_v_r <= 1'b0;
              state_r     <= ARMED;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          spi_MISO <= 1'b0;
          miso_oe  <= 1'b0;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
